// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: multicycle data-memory access sequencer.
// Takes decoder read/write strobes, issues one request pulse to a handshaked
// memory, stalls the pipeline until ack or timeout, and returns read data.
// A HALT seen in IDLE parks the block until reset.
// Optional build macro: MEM_ALIGN_CHECK_EN rejects odd addresses without
// touching memory (err pulse, no request).
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        halt,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        m_rd,
  output logic        m_wr,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic        m_ack,
  input  logic [15:0] m_rdata,
  output logic        stall,
  output logic [15:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic        halted
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DONE   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  state_t           state;
  logic             op_wr;
  logic [CNT_W-1:0] cnt;
  logic             start;
  logic             misalign;

  assign start = (mem_read | mem_write) & ~halt;

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = addr[0];
`else
  assign misalign = 1'b0;
`endif

  // Pipeline hold: asserted on the accept cycle and while a request is in flight.
  assign stall = ((state == ST_IDLE) & start) | (state == ST_REQ) | (state == ST_WAIT);

  // Sequencer state, latched operands and registered memory/pipeline outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_wr       <= 1'b0;
      cnt         <= '0;
      m_rd        <= 1'b0;
      m_wr        <= 1'b0;
      m_addr      <= '0;
      m_wdata     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      halted      <= 1'b0;
    end else begin
      m_rd        <= 1'b0;
      m_wr        <= 1'b0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (halt) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end else if (start) begin
            m_addr  <= addr;
            m_wdata <= wdata;
            op_wr   <= mem_write;
            if (misalign) begin
              state <= ST_DONE;
              err   <= 1'b1;
            end else begin
              state <= ST_REQ;
              m_rd  <= ~mem_write;
              m_wr  <= mem_write;
            end
          end
        end
        ST_REQ: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Ack wins over a timeout landing in the same cycle.
          if (m_ack) begin
            if (!op_wr) begin
              rdata       <= m_rdata;
              rdata_valid <= 1'b1;
            end
            state <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            err   <= 1'b1;
            state <= ST_DONE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        ST_HALTED: begin
          state  <= ST_HALTED;
          halted <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed self-checking bench for mem_access_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are checked
// 2 units after the edge. Per-cycle event counts are taken on the falling edge.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write, halt;
  logic [15:0] addr, wdata;
  logic        m_rd, m_wr;
  logic [15:0] m_addr, m_wdata;
  logic        m_ack;
  logic [15:0] m_rdata;
  logic        stall;
  logic [15:0] rdata;
  logic        rdata_valid, err, halted;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned stall_n = 0, rd_n = 0, wr_n = 0, rv_n = 0, err_n = 0;
  int unsigned s_stall, s_rd, s_wr, s_rv, s_err;

  mem_access_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .halt(halt),
    .addr(addr), .wdata(wdata),
    .m_rd(m_rd), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_rdata(m_rdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .err(err), .halted(halted)
  );

  always #5 clk = ~clk;

  // Mid-cycle event counters.
  always @(negedge clk) begin
    if (stall === 1'b1)       stall_n++;
    if (m_rd === 1'b1)        rd_n++;
    if (m_wr === 1'b1)        wr_n++;
    if (rdata_valid === 1'b1) rv_n++;
    if (err === 1'b1)         err_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_stall = stall_n; s_rd = rd_n; s_wr = wr_n; s_rv = rv_n; s_err = err_n;
  endtask

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; halt = 1'b0;
    addr = '0; wdata = '0; m_ack = 1'b0; m_rdata = '0;
    #2;
    check("rst_m_rd", m_rd, 0);
    check("rst_m_wr", m_wr, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rv", rdata_valid, 0);
    check("rst_err", err, 0);
    check("rst_halted", halted, 0);
    check("rst_stall", stall, 0);
    nxt(); rst_n = 1'b1;

    // Read 0x0040, ack in first WAIT cycle
    nxt(); snap(); mem_read = 1'b1; addr = 16'h0040; #1;
    check("t1_accept_stall", stall, 1);
    check("t1_accept_m_rd", m_rd, 0);
    nxt(); mem_read = 1'b0; addr = 16'hFFFF; #1;
    check("t1_req_m_rd", m_rd, 1);
    check("t1_req_m_addr", m_addr, 16'h0040);
    check("t1_req_stall", stall, 1);
    nxt(); m_ack = 1'b1; m_rdata = 16'hBEEF; #1;
    check("t1_wait_stall", stall, 1);
    nxt(); m_ack = 1'b0; m_rdata = 16'h0000; #1;
    check("t1_done_stall", stall, 0);
    check("t1_done_rdata", rdata, 16'hBEEF);
    check("t1_done_rv", rdata_valid, 1);
    nxt();
    check("t1_stall_cycles", stall_n - s_stall, 3);
    check("t1_rd_pulses", rd_n - s_rd, 1);
    check("t1_wr_pulses", wr_n - s_wr, 0);
    check("t1_rv_pulses", rv_n - s_rv, 1);

    // Store with both strobes, ack on 4th WAIT cycle (back-to-back start)
    snap(); mem_read = 1'b1; mem_write = 1'b1; addr = 16'h0010; wdata = 16'h1234; #1;
    check("t2_accept_stall", stall, 1);
    nxt(); mem_read = 1'b0; mem_write = 1'b0; wdata = 16'h0000; #1;
    check("t2_req_m_wr", m_wr, 1);
    check("t2_req_m_rd", m_rd, 0);
    check("t2_req_m_wdata", m_wdata, 16'h1234);
    check("t2_req_m_addr", m_addr, 16'h0010);
    repeat (3) nxt();
    nxt(); m_ack = 1'b1; m_rdata = 16'hDEAD; #1;
    check("t2_wait4_stall", stall, 1);
    nxt(); m_ack = 1'b0; #1;
    check("t2_done_stall", stall, 0);
    check("t2_done_rv", rdata_valid, 0);
    check("t2_done_rdata", rdata, 16'hBEEF);
    check("t2_done_err", err, 0);
    nxt();
    check("t2_stall_cycles", stall_n - s_stall, 6);
    check("t2_wr_pulses", wr_n - s_wr, 1);
    check("t2_rd_pulses", rd_n - s_rd, 0);
    check("t2_rv_pulses", rv_n - s_rv, 0);

    // Timeout: no ack for 15 WAIT cycles
    snap(); mem_read = 1'b1; addr = 16'h0080; #1;
    nxt(); mem_read = 1'b0;
    repeat (15) nxt();
    #1;
    check("t3_last_wait_err", err, 0);
    check("t3_last_wait_stall", stall, 1);
    nxt(); #1;
    check("t3_done_err", err, 1);
    check("t3_done_stall", stall, 0);
    check("t3_done_rv", rdata_valid, 0);
    nxt(); #1;
    check("t3_err_cleared", err, 0);
    check("t3_stall_cycles", stall_n - s_stall, 17);
    check("t3_err_pulses", err_n - s_err, 1);
    check("t3_rd_pulses", rd_n - s_rd, 1);
    // Follow-up read succeeds
    mem_read = 1'b1; addr = 16'h0082;
    nxt(); mem_read = 1'b0;
    nxt(); m_ack = 1'b1; m_rdata = 16'hCAFE;
    nxt(); m_ack = 1'b0; #1;
    check("t3_after_rdata", rdata, 16'hCAFE);
    check("t3_after_rv", rdata_valid, 1);
    check("t3_after_err", err, 0);
    // Ack on the final allowed WAIT cycle wins over timeout
    nxt(); snap(); mem_read = 1'b1; addr = 16'h0084;
    nxt(); mem_read = 1'b0;
    repeat (14) nxt();
    nxt(); m_ack = 1'b1; m_rdata = 16'h5A5A; #1;
    check("t3_edge_stall", stall, 1);
    nxt(); m_ack = 1'b0; #1;
    check("t3_edge_err", err, 0);
    check("t3_edge_rv", rdata_valid, 1);
    check("t3_edge_rdata", rdata, 16'h5A5A);

    // Odd address read
    nxt(); snap(); mem_read = 1'b1; addr = 16'h0041; #1;
    check("t4_accept_stall", stall, 1);
    nxt(); mem_read = 1'b0; #1;
`ifdef MEM_ALIGN_CHECK_EN
    check("t4_align_m_rd", m_rd, 0);
    check("t4_align_err", err, 1);
    check("t4_align_stall", stall, 0);
    check("t4_align_rv", rdata_valid, 0);
`else
    check("t4_odd_m_rd", m_rd, 1);
    check("t4_odd_m_addr", m_addr, 16'h0041);
`endif
    nxt(); m_ack = 1'b1; m_rdata = 16'h1111;
    nxt(); m_ack = 1'b0; #1;
`ifdef MEM_ALIGN_CHECK_EN
    check("t4_align_rdata", rdata, 16'h5A5A);
    check("t4_align_rv_late", rdata_valid, 0);
`else
    check("t4_odd_rdata", rdata, 16'h1111);
    check("t4_odd_rv", rdata_valid, 1);
`endif
    nxt();
`ifdef MEM_ALIGN_CHECK_EN
    check("t4_align_stall_cycles", stall_n - s_stall, 1);
    check("t4_align_rd_pulses", rd_n - s_rd, 0);
`else
    check("t4_odd_stall_cycles", stall_n - s_stall, 3);
    check("t4_odd_rd_pulses", rd_n - s_rd, 1);
`endif

    // Reset during REQ clears the request pulse at once
    mem_read = 1'b1; addr = 16'h00A0;
    nxt(); mem_read = 1'b0; #1;
    check("t5_req_m_rd", m_rd, 1);
    rst_n = 1'b0; #1;
    check("t5_rst_m_rd", m_rd, 0);
    check("t5_rst_stall", stall, 0);
    check("t5_rst_m_addr", m_addr, 0);
    check("t5_rst_rdata", rdata, 0);
    nxt(); rst_n = 1'b1;
    // Reset during WAIT, then a late ack is ignored
    nxt(); mem_read = 1'b1; addr = 16'h00B0;
    nxt(); mem_read = 1'b0;
    nxt();
    nxt(); #1;
    check("t5_wait_stall", stall, 1);
    rst_n = 1'b0; #1;
    check("t5_wrst_stall", stall, 0);
    check("t5_wrst_m_rd", m_rd, 0);
    check("t5_wrst_err", err, 0);
    check("t5_wrst_rv", rdata_valid, 0);
    nxt(); rst_n = 1'b1; m_ack = 1'b1; m_rdata = 16'h7777; #1;
    check("t5_late_ack_stall", stall, 0);
    nxt(); #1;
    check("t5_late_ack_rdata", rdata, 0);
    check("t5_late_ack_rv", rdata_valid, 0);
    nxt(); m_ack = 1'b0;

    // Halt in IDLE (with a strobe present) parks the block
    snap(); halt = 1'b1; mem_read = 1'b1; addr = 16'h00C0; #1;
    check("t6_halt_stall", stall, 0);
    nxt(); halt = 1'b0; #1;
    check("t6_halted", halted, 1);
    check("t6_halted_stall", stall, 0);
    repeat (4) nxt();
    mem_read = 1'b0;
    nxt(); #1;
    check("t6_rd_pulses", rd_n - s_rd, 0);
    check("t6_wr_pulses", wr_n - s_wr, 0);
    check("t6_stall_cycles", stall_n - s_stall, 0);
    check("t6_still_halted", halted, 1);
    rst_n = 1'b0; #1;
    check("t6_rst_halted", halted, 0);
    nxt(); rst_n = 1'b1;
    nxt(); mem_read = 1'b1; addr = 16'h00C0;
    nxt(); mem_read = 1'b0;
    nxt(); m_ack = 1'b1; m_rdata = 16'h4242;
    nxt(); m_ack = 1'b0; #1;
    check("t6_resume_rdata", rdata, 16'h4242);
    check("t6_resume_rv", rdata_valid, 1);
    check("t6_resume_halted", halted, 0);

    nxt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
